// File: rtl/credit_pkg.sv
// Shared types and helpers for the credit link (transmitter and receiver side).
package credit_pkg;

  typedef enum logic [1:0] {S_INIT, S_RUN, S_ERR} credit_state_t;

  function automatic int credit_cnt_w(int credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Saturating up/down credit counter; loads CREDITS on reset, flags an attempted overflow.
module credit_counter
  import credit_pkg::*;
#(
  parameter int CREDITS = 8,
  parameter int CNT_W   = credit_cnt_w(CREDITS)
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             en,
  input  logic             dec,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDITS);

  // Overflow is reported in the same cycle so the owner can react on this edge.
  assign ovf = en & inc & ~dec & (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      cnt <= CNT_MAX;
    end else if (en) begin
      if (inc && !dec && cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
      else if (dec && !inc && cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/credit_tx.sv
// Credit-based transmitter: forwards source words to a remote FIFO only while credits remain.
//   state  | meaning
//   S_INIT | wait INIT_CYCLES after reset so the receiver finishes its reset
//   S_RUN  | accept and forward words, track credits
//   S_ERR  | credit returned beyond CREDITS; frozen until reset
module credit_tx
  import credit_pkg::*;
#(
  parameter  int WIDTH       = 8,
  parameter  int CREDITS     = 8,
  parameter  int INIT_CYCLES = 2,
  localparam int CNT_W       = credit_cnt_w(CREDITS)
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_we,
  input  logic             credit_i,
  output logic [CNT_W-1:0] credit_cnt,
  output logic             credit_err,
  output logic             idle
);

  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [INIT_W-1:0] INIT_LAST = (INIT_CYCLES > 1) ? INIT_W'(INIT_CYCLES - 1) : '0;

  credit_state_t     state;
  logic [INIT_W-1:0] init_cnt;
  logic              acc;
  logic              ovf;

  assign s_ready = (state == S_RUN) && (credit_cnt != '0);
  assign acc     = s_valid & s_ready;
  assign idle    = (credit_cnt == CNT_W'(CREDITS)) && !tx_we;

  // Credits only move in S_RUN; returns in S_INIT/S_ERR are dropped.
  credit_counter #(
    .CREDITS (CREDITS),
    .CNT_W   (CNT_W)
  ) u_counter (
    .clk     (clk),
    .reset_p (reset_p),
    .en      (state == S_RUN),
    .dec     (acc),
    .inc     (credit_i),
    .cnt     (credit_cnt),
    .ovf     (ovf)
  );

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state      <= S_INIT;
      init_cnt   <= '0;
      tx_we      <= 1'b0;
      tx_data    <= '0;
      credit_err <= 1'b0;
    end else begin
      tx_we <= acc;
      if (acc)
        tx_data <= s_data;
      case (state)
        S_INIT: begin
          if (init_cnt == INIT_LAST)
            state <= S_RUN;
          else
            init_cnt <= init_cnt + 1'b1;
        end
        S_RUN: begin
          if (ovf) begin
            state      <= S_ERR;
            credit_err <= 1'b1;
          end
        end
        S_ERR:   state <= S_ERR;
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_credit_tx.sv
// Self-checking bench for credit_tx: vector table, corner-case sequences and a remote FIFO model.
module tb_credit_tx;

  logic       clk = 1'b0;
  logic       reset_p;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] tx_data;
  logic       tx_we;
  logic       credit_i;
  logic [3:0] credit_cnt;
  logic       credit_err;
  logic       idle;

  credit_tx #(.WIDTH(8), .CREDITS(8), .INIT_CYCLES(2)) dut (
    .clk        (clk),
    .reset_p    (reset_p),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .tx_data    (tx_data),
    .tx_we      (tx_we),
    .credit_i   (credit_i),
    .credit_cnt (credit_cnt),
    .credit_err (credit_err),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_we  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each accepted word must appear on tx_data exactly one cycle later, in order.
  logic [7:0] sbq[$];
  logic       exp_we = 1'b0;
  logic [7:0] exp_d;

  always @(negedge clk) begin
    if (reset_p) begin
      sbq.delete();
      exp_we = 1'b0;
    end else begin
      chk("tx_we_latency", 32'(tx_we), 32'(exp_we));
      if (tx_we) begin
        n_we++;
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tx_unexpected: got word %0h, expected no word", tx_data);
        end else begin
          exp_d = sbq.pop_front();
          chk("tx_order", 32'(tx_data), 32'(exp_d));
        end
      end
      exp_we = s_valid & s_ready;
      if (exp_we) sbq.push_back(s_data);
    end
  end

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       ci;
    logic       rdy;
    logic [3:0] cnt;
    logic       idl;
  } vec_t;

  vec_t tbl[17];

  int         base;
  int         sent;
  int         rcvd;
  logic [7:0] rxq[$];
  logic [7:0] rx_exp;
  logic [7:0] rx_got;
  logic       pop;
  logic       prev_we;
  logic       prev_pop;
  logic [7:0] prev_data;

  initial begin
    // v, data, credit_i | s_ready, credit_cnt, idle seen before the edge
    tbl[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 4'd8, 1'b1};
    tbl[1]  = '{1'b1, 8'h01, 1'b0, 1'b0, 4'd8, 1'b1};
    tbl[2]  = '{1'b1, 8'h01, 1'b0, 1'b1, 4'd8, 1'b1};
    tbl[3]  = '{1'b1, 8'h02, 1'b0, 1'b1, 4'd7, 1'b0};
    tbl[4]  = '{1'b1, 8'h03, 1'b0, 1'b1, 4'd6, 1'b0};
    tbl[5]  = '{1'b1, 8'h04, 1'b0, 1'b1, 4'd5, 1'b0};
    tbl[6]  = '{1'b1, 8'h05, 1'b0, 1'b1, 4'd4, 1'b0};
    tbl[7]  = '{1'b1, 8'h06, 1'b0, 1'b1, 4'd3, 1'b0};
    tbl[8]  = '{1'b1, 8'h07, 1'b0, 1'b1, 4'd2, 1'b0};
    tbl[9]  = '{1'b1, 8'h08, 1'b0, 1'b1, 4'd1, 1'b0};
    tbl[10] = '{1'b1, 8'h09, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[11] = '{1'b1, 8'h09, 1'b1, 1'b0, 4'd0, 1'b0};
    tbl[12] = '{1'b1, 8'h09, 1'b0, 1'b1, 4'd1, 1'b0};
    tbl[13] = '{1'b1, 8'h0A, 1'b1, 1'b0, 4'd0, 1'b0};
    tbl[14] = '{1'b1, 8'h0A, 1'b0, 1'b1, 4'd1, 1'b0};
    tbl[15] = '{1'b0, 8'h0A, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[16] = '{1'b0, 8'h0A, 1'b0, 1'b0, 4'd0, 1'b0};

    reset_p  = 1'b1;
    s_valid  = 1'b0;
    s_data   = 8'h00;
    credit_i = 1'b0;
    step();
    step();
    chk("rst_tx_we", 32'(tx_we), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_credit_cnt", 32'(credit_cnt), 32'd8);
    chk("rst_credit_err", 32'(credit_err), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    reset_p = 1'b0;

    // Init wait, 8-word burst draining credits, then two single credit returns.
    for (int i = 0; i < 17; i++) begin
      s_valid  = tbl[i].v;
      s_data   = tbl[i].d;
      credit_i = tbl[i].ci;
      chk($sformatf("tbl%0d_s_ready", i), 32'(s_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_credit_cnt", i), 32'(credit_cnt), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_idle", i), 32'(idle), 32'(tbl[i].idl));
      step();
    end
    chk("burst_we_count", 32'(n_we), 32'd10);

    // Steady state at 3 credits with simultaneous accept and return.
    credit_i = 1'b1;
    for (int i = 0; i < 3; i++) step();
    credit_i = 1'b0;
    chk("steady_start_cnt", 32'(credit_cnt), 32'd3);
    base = n_we;
    for (int i = 0; i < 20; i++) begin
      s_valid  = 1'b1;
      s_data   = 8'(8'h10 + i);
      credit_i = 1'b1;
      chk($sformatf("steady%0d_s_ready", i), 32'(s_ready), 32'd1);
      chk($sformatf("steady%0d_cnt", i), 32'(credit_cnt), 32'd3);
      step();
    end
    s_valid  = 1'b0;
    credit_i = 1'b0;
    chk("steady_end_cnt", 32'(credit_cnt), 32'd3);
    step();
    step();
    chk("steady_we_count", 32'(n_we - base), 32'd20);

    // Refill to CREDITS, then one extra return overflows into S_ERR.
    credit_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    credit_i = 1'b0;
    chk("full_cnt", 32'(credit_cnt), 32'd8);
    chk("full_idle", 32'(idle), 32'd1);
    chk("full_err", 32'(credit_err), 32'd0);
    credit_i = 1'b1;
    step();
    credit_i = 1'b0;
    chk("ovf_err", 32'(credit_err), 32'd1);
    chk("ovf_s_ready", 32'(s_ready), 32'd0);
    chk("ovf_cnt", 32'(credit_cnt), 32'd8);
    base = n_we;
    s_valid = 1'b1;
    s_data  = 8'h5A;
    step();
    credit_i = 1'b1;
    step();
    credit_i = 1'b0;
    step();
    step();
    s_valid = 1'b0;
    chk("err_no_tx", 32'(n_we - base), 32'd0);
    chk("err_cnt_frozen", 32'(credit_cnt), 32'd8);
    chk("err_sticky", 32'(credit_err), 32'd1);
    chk("err_s_ready", 32'(s_ready), 32'd0);
    reset_p = 1'b1;
    #1;
    chk("err_cleared_by_reset", 32'(credit_err), 32'd0);
    step();
    reset_p = 1'b0;

    // Init repeats after reset; credit_i during S_INIT is ignored.
    s_valid  = 1'b1;
    s_data   = 8'h31;
    credit_i = 1'b1;
    chk("init0_s_ready", 32'(s_ready), 32'd0);
    step();
    credit_i = 1'b0;
    chk("init1_s_ready", 32'(s_ready), 32'd0);
    chk("init_credit_ignored", 32'(credit_cnt), 32'd8);
    chk("init_no_err", 32'(credit_err), 32'd0);
    step();
    chk("init_done_s_ready", 32'(s_ready), 32'd1);
    step();
    s_data = 8'h32;
    step();
    s_data = 8'h33;
    step();
    chk("pre_rst_tx_we", 32'(tx_we), 32'd1);
    chk("pre_rst_tx_data", 32'(tx_data), 32'h33);
    chk("pre_rst_cnt", 32'(credit_cnt), 32'd5);
    #2;
    reset_p = 1'b1;
    #1;
    chk("async_rst_tx_we", 32'(tx_we), 32'd0);
    chk("async_rst_s_ready", 32'(s_ready), 32'd0);
    chk("async_rst_cnt", 32'(credit_cnt), 32'd8);
    chk("async_rst_idle", 32'(idle), 32'd1);
    step();
    reset_p = 1'b0;
    s_valid = 1'b0;
    chk("reinit0_s_ready", 32'(s_ready), 32'd0);
    step();
    chk("reinit1_s_ready", 32'(s_ready), 32'd0);
    step();
    chk("reinit_done_s_ready", 32'(s_ready), 32'd1);

    // Remote 8-deep FIFO model popped at random; each pop returns one credit.
    sent      = 0;
    rcvd      = 0;
    prev_we   = 1'b0;
    prev_pop  = 1'b0;
    prev_data = 8'h00;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (prev_pop) begin
        if (rxq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rx_underflow: got empty FIFO, expected word %0d", rcvd);
        end else begin
          rx_exp = rcvd[7:0];
          rx_got = rxq.pop_front();
          chk("rx_order", 32'(rx_got), 32'(rx_exp));
        end
        rcvd++;
      end
      if (prev_we) rxq.push_back(prev_data);
      chk("rx_no_overflow", 32'(rxq.size() <= 8), 32'd1);
      chk("credit_conservation", 32'(credit_cnt) + 32'(rxq.size()) + 32'(tx_we), 32'd8);
      if (rcvd >= 1000) break;
      pop      = (rxq.size() > 0) && ($urandom_range(0, 2) != 0);
      credit_i = pop;
      s_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      s_data   = sent[7:0];
      prev_we   = tx_we;
      prev_data = tx_data;
      prev_pop  = pop;
      if (s_valid && s_ready) sent++;
      step();
    end
    credit_i = 1'b0;
    s_valid  = 1'b0;
    chk("rand_words_received", 32'(rcvd), 32'd1000);
    chk("rand_words_sent", 32'(sent), 32'd1000);
    chk("rand_final_cnt", 32'(credit_cnt), 32'd8);
    chk("rand_final_idle", 32'(idle), 32'd1);
    chk("rand_no_err", 32'(credit_err), 32'd0);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/credit_tx.md
Name: credit_tx

Overview:
- Credit-based transmitter: the sending end of the credit link whose receiving end is an 8-deep FIFO with data_we write port, plus a credit return.
- Accepts words from a local valid/ready source.
- Forwards a word to the remote FIFO only while it holds a credit; one credit is spent per word.
- Regains one credit per credit_i pulse, which the receiver issues for each word it pops. The remote FIFO therefore never overflows.

Parameters:
- WIDTH, 8, data word width in bits.
- CREDITS, 8, initial credit count; equals the remote FIFO depth. Must be at least 1.
- INIT_CYCLES, 2, cycles s_ready is held low after reset release, so the receiver's registered reset can complete.
- Derived localparam CNT_W = $clog2(CREDITS+1).

Ports:
- clk  in  1  clock.
- reset_p  in  1  asynchronous active-high reset; 1 = reset.
- s_data  in  WIDTH  source word.
- s_valid  in  1  source word valid.
- s_ready  out  1  transmitter accepts s_data in this cycle.
- tx_data  out  WIDTH  word to the remote FIFO data_i.
- tx_we  out  1  write strobe to the remote FIFO data_we; one-cycle pulse per word.
- credit_i  in  1  credit return; one pulse = one word freed at the receiver.
- credit_cnt  out  CNT_W  current credits held.
- credit_err  out  1  sticky: credit return beyond CREDITS.
- idle  out  1  credit_cnt==CREDITS and tx_we==0, i.e. all words acknowledged.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high; reset_p clears all state immediately, independent of clk.
- Reset values: state=S_INIT, init counter=0, credit_cnt=CREDITS, tx_we=0, tx_data=0, credit_err=0, s_ready=0, idle=1.
- FSM states:
  - S_INIT: count INIT_CYCLES clocks, then go to S_RUN. s_ready=0. credit_i is ignored.
  - S_RUN: normal operation.
  - S_ERR: terminal state; leaves only on reset_p. s_ready=0, tx_we=0, credit_i ignored, credit_cnt frozen.
- s_ready is combinational: (state==S_RUN) && (credit_cnt!=0). It does not depend on s_valid.
- Accept: acc = s_valid & s_ready.
- Send: on the clock edge where acc=1, register tx_data<=s_data and tx_we<=1. Otherwise tx_we<=0 and tx_data holds its value. Latency is exactly 1 cycle from acceptance to tx_we.
- Credit arithmetic, evaluated at each edge in S_RUN: next = credit_cnt - acc + credit_i.
  - acc and credit_i in the same cycle: credit_cnt is unchanged and the word is still sent.
  - credit_cnt==0 with credit_i=1: s_ready stays 0 in that cycle; the credit becomes usable the next cycle.
- Overflow: if next > CREDITS (only possible when credit_cnt==CREDITS, credit_i=1, acc=0):
  - credit_err<=1.
  - state<=S_ERR.
  - credit_cnt stays CREDITS (saturate; never wraps).
- Ordering: words reach tx_data strictly in acceptance order. No internal buffering beyond the single output register.
- Throughput: one word per cycle while credits are available. A burst of CREDITS words drains the credits. With no return, s_ready=0 from the cycle after the last credit is spent.
- Reset mid-operation:
  - reset_p asserted while tx_we=1 clears tx_we asynchronously.
  - A word already accepted but whose tx_we was cleared is lost.
  - The receiver is reset by the same reset_p, so credits are consistent again after reset.
- Illegal credit_i in S_INIT or S_ERR: ignored; it does not set credit_err.

Decomposition:
- Package credit_pkg:
  - typedef enum logic [1:0] {S_INIT, S_RUN, S_ERR} credit_state_t.
  - function credit_cnt_w(int credits) returning $clog2(credits+1).
- One natural sub-module: credit_counter.
  - Ports: clk, reset_p, en, dec, inc, cnt, ovf.
  - Saturating up/down counter with reset load value CREDITS.
  - Reused later by the receiver-side credit issuer.
- The FSM and output register stay in credit_tx.

Test Plan:
- Reset release, s_valid=1 constantly, CREDITS=8, INIT_CYCLES=2 -> s_ready=0 for 2 cycles, then high; first tx_we exactly 1 cycle after the first acceptance.
- Burst of 10 words 0x01..0x0A, no credit_i -> exactly 8 tx_we pulses carrying 0x01..0x08; credit_cnt reaches 0; s_ready=0; 0x09 is held at the source.
- From the previous state, pulse credit_i twice one cycle apart -> 0x09, 0x0A sent in order, each 1 cycle after its acceptance; credit_cnt ends at 0.
- Steady state with credit_cnt=3, s_valid=1 and credit_i=1 every cycle for 20 cycles -> 20 consecutive tx_we pulses; credit_cnt stays 3.
- Idle with credit_cnt=8, inject credit_i=1 -> credit_err=1 next edge; state S_ERR; s_ready=0; credit_cnt=8; further s_valid produces no tx_we; reset_p clears credit_err.
- Assert reset_p asynchronously (between edges) while tx_we=1 and credit_cnt=5 -> tx_we, s_ready drop immediately; after release credit_cnt=8 and the S_INIT wait repeats.
- Scoreboard: a reference model of an 8-deep FIFO popped at random rate, with credit_i = pop -> the model never overflows; data order matches over 1000 random words.
